// File: rtl/decoder_acc_relu_23s_16s.sv
// decoder_acc_relu_23s_16s
//   Accumulates N_TERMS signed multiplier products per neuron, starting from a
//   bias scaled up by FRAC_SHIFT. The sum is requantized with round-half-up and
//   an arithmetic right shift, optionally clamped by ReLU, then saturated to an
//   OUT_WIDTH activation. One result is produced per N_TERMS accepted products.
//
// Ports
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset
//   clear        synchronous abort; drops the partial sum and returns to idle
//   bias         signed bias at output scale, taken on the first beat of a vector
//   prod_tdata   signed product input
//   prod_tvalid  product valid
//   prod_tready  product accepted (low while a result is pending, in reset or on clear)
//   out_tdata    requantized activation, held while out_tvalid is high
//   out_tvalid   activation valid
//   out_tready   downstream accepts activation
//   busy         high while accumulating or presenting a result
module decoder_acc_relu_23s_16s #(
    parameter int PROD_WIDTH = 23,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int N_TERMS    = 16,
    parameter int FRAC_SHIFT = 6,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         clear,
    input  logic signed [OUT_WIDTH-1:0]  bias,
    input  logic signed [PROD_WIDTH-1:0] prod_tdata,
    input  logic                         prod_tvalid,
    output logic                         prod_tready,
    output logic signed [OUT_WIDTH-1:0]  out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic                         busy
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    localparam logic signed [ACC_WIDTH-1:0] ROUND  = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                         state, state_nxt;
    logic signed [ACC_WIDTH-1:0]    acc, acc_nxt;
    logic        [CNT_W-1:0]        cnt, cnt_nxt;
    logic                           load_out;

    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    rounded;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic signed [OUT_WIDTH-1:0]    out_nxt;

    // Casting the signed ports sign-extends them to accumulator width.
    assign bias_ext = ACC_WIDTH'(bias) <<< FRAC_SHIFT;
    assign prod_ext = ACC_WIDTH'(prod_tdata);

    // Gating with ap_rst_n keeps ready low for the whole reset, even though
    // the state register already reads IDLE.
    assign prod_tready = ap_rst_n && !clear && (state != S_OUT);
    assign out_tvalid  = (state == S_OUT);
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        load_out  = 1'b0;
        if (clear) begin
            state_nxt = S_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (prod_tvalid) begin
                        acc_nxt = bias_ext + prod_ext;
                        cnt_nxt = CNT_W'(1);
                        if (N_TERMS == 1) begin
                            state_nxt = S_OUT;
                            load_out  = 1'b1;
                        end else begin
                            state_nxt = S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (prod_tvalid) begin
                        acc_nxt = acc + prod_ext;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state_nxt = S_OUT;
                            load_out  = 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_tready) begin
                        state_nxt = S_IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Requantize the value being written on the final beat so the result is
    // registered together with the transition into S_OUT.
    always_comb begin
        rounded = acc_nxt + ROUND;
        shifted = rounded >>> FRAC_SHIFT;
        if (RELU_EN && shifted[ACC_WIDTH-1]) begin
            out_nxt = '0;
        end else if (shifted > SAT_HI) begin
            out_nxt = SAT_HI[OUT_WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            out_nxt = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            out_nxt = shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_tdata <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            if (load_out) begin
                out_tdata <= out_nxt;
            end
        end
    end

endmodule

// File: tb/tb_decoder_acc_relu_23s_16s.sv
module tb_decoder_acc_relu_23s_16s;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               clear;
    logic signed [15:0] bias;
    logic signed [22:0] prod_tdata;
    logic               prod_tvalid;
    logic               out_tready;

    logic               prod_tready, out_tvalid, busy;
    logic signed [15:0] out_tdata;
    logic               nr_prod_tready, nr_out_tvalid, nr_busy;
    logic signed [15:0] nr_out_tdata;

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    decoder_acc_relu_23s_16s #(
        .PROD_WIDTH(23), .ACC_WIDTH(32), .OUT_WIDTH(16),
        .N_TERMS(4), .FRAC_SHIFT(6), .RELU_EN(1'b1)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear), .bias(bias),
        .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .busy(busy)
    );

    decoder_acc_relu_23s_16s #(
        .PROD_WIDTH(23), .ACC_WIDTH(32), .OUT_WIDTH(16),
        .N_TERMS(4), .FRAC_SHIFT(6), .RELU_EN(1'b0)
    ) dut_nr (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear), .bias(bias),
        .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(nr_prod_tready),
        .out_tdata(nr_out_tdata), .out_tvalid(nr_out_tvalid), .out_tready(out_tready),
        .busy(nr_busy)
    );

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic signed [22:0] p, output bit ok);
        ok = 1'b0;
        prod_tdata  = p;
        prod_tvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (prod_tready) ok = 1'b1;
            @(negedge ap_clk);
        end
        prod_tvalid = 1'b0;
    endtask

    task automatic send4(input logic signed [15:0] b,
                         input logic signed [22:0] p0, input logic signed [22:0] p1,
                         input logic signed [22:0] p2, input logic signed [22:0] p3,
                         output bit ok);
        bit k;
        ok = 1'b1;
        bias = b;
        push(p0, k); ok &= k;
        push(p1, k); ok &= k;
        push(p2, k); ok &= k;
        push(p3, k); ok &= k;
    endtask

    // Waits for a result, captures both DUT outputs and completes the handshake.
    task automatic take(output logic signed [15:0] d, output logic signed [15:0] dn,
                        output bit ok);
        ok = 1'b0;
        d  = '0;
        dn = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (out_tvalid && nr_out_tvalid) ok = 1'b1;
            else @(negedge ap_clk);
        end
        if (ok) begin
            d  = out_tdata;
            dn = nr_out_tdata;
            out_tready = 1'b1;
            @(negedge ap_clk);
            out_tready = 1'b0;
        end
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        #2;
        checks++;
        if ({prod_tready, out_tvalid, busy} !== 3'b000 || out_tdata !== 16'sd0) begin
            failures++;
            $display("FAIL reset_state: ready/valid/busy=%b data=%0d, required 000 and 0",
                     {prod_tready, out_tvalid, busy}, out_tdata);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (prod_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 1", prod_tready);
        end
        @(negedge ap_clk);
    endtask

    task automatic test_basic;
        bit ok, ok2;
        logic signed [15:0] d, dn;
        send4(16'sd0, 23'sd64, 23'sd128, 23'sd192, -23'sd64, ok);
        checks++;
        if (!ok || out_tvalid !== 1'b1 || prod_tready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency: ok=%b valid=%b ready=%b busy=%b, required 1 1 0 1",
                     ok, out_tvalid, prod_tready, busy);
        end
        take(d, dn, ok2);
        checks++;
        if (!ok2 || d !== 16'sd5 || dn !== 16'sd5) begin
            failures++;
            $display("FAIL basic_value: got %0d/%0d, required 5/5", d, dn);
        end
    endtask

    task automatic test_relu;
        bit ok, ok2;
        logic signed [15:0] d, dn;
        send4(16'sd0, -23'sd640, -23'sd640, -23'sd640, -23'sd640, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd0 || dn !== -16'sd40) begin
            failures++;
            $display("FAIL relu_neg640: got relu=%0d plain=%0d, required 0 and -40", d, dn);
        end
        send4(16'sd0, -23'sd96, 23'sd0, 23'sd0, 23'sd0, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd0 || dn !== -16'sd1) begin
            failures++;
            $display("FAIL relu_round_neg: got relu=%0d plain=%0d, required 0 and -1", d, dn);
        end
    endtask

    task automatic test_saturation;
        bit ok, ok2;
        logic signed [15:0] d, dn;
        send4(16'sd32767, 23'sd4194303, 23'sd4194303, 23'sd4194303, 23'sd4194303, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd32767 || dn !== 16'sd32767) begin
            failures++;
            $display("FAIL sat_pos: got %0d/%0d, required 32767/32767", d, dn);
        end
        send4(-16'sd32768, -23'sd4194304, -23'sd4194304, -23'sd4194304, -23'sd4194304, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd0 || dn !== -16'sd32768) begin
            failures++;
            $display("FAIL sat_neg: got relu=%0d plain=%0d, required 0 and -32768", d, dn);
        end
    endtask

    task automatic test_bias_hold;
        bit ok, k, ok2;
        logic signed [15:0] d, dn;
        bias = 16'sd100;
        push(23'sd0, ok);
        bias = -16'sd100;
        push(23'sd0, k); ok &= k;
        push(23'sd0, k); ok &= k;
        push(23'sd0, k); ok &= k;
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd100 || dn !== 16'sd100) begin
            failures++;
            $display("FAIL bias_hold: got %0d/%0d, required 100/100", d, dn);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, ok2;
        int bad;
        logic signed [15:0] d, dn;
        send4(16'sd0, 23'sd64, 23'sd64, 23'sd64, 23'sd64, ok);
        // Offer the next vector's first product while the result is stalled.
        bias        = 16'sd0;
        prod_tdata  = 23'sd640;
        prod_tvalid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_tvalid !== 1'b1 || out_tdata !== 16'sd4 || prod_tready !== 1'b0) bad++;
            @(negedge ap_clk);
        end
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL stall_hold: %0d bad cycles (ok=%b), required 0", bad, ok);
        end
        out_tready = 1'b1;
        #1;
        checks++;
        if (prod_tready !== 1'b0) begin
            failures++;
            $display("FAIL handshake_cycle_ready: got %b, required 0", prod_tready);
        end
        @(negedge ap_clk);
        out_tready = 1'b0;
        #1;
        checks++;
        if (prod_tready !== 1'b1 || out_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL after_handshake: ready=%b valid=%b, required 1 0",
                     prod_tready, out_tvalid);
        end
        @(negedge ap_clk);
        prod_tvalid = 1'b0;
        push(23'sd0, ok);
        push(23'sd0, ok2); ok &= ok2;
        push(23'sd0, ok2); ok &= ok2;
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd10 || dn !== 16'sd10) begin
            failures++;
            $display("FAIL back_to_back_value: got %0d/%0d, required 10/10", d, dn);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, ok2;
        logic signed [15:0] d, dn;
        bias = 16'sd5;
        push(23'sd1000, ok);
        push(23'sd1000, ok2); ok &= ok2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {prod_tready, out_tvalid, busy} !== 3'b000 || out_tdata !== 16'sd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: ready/valid/busy=%b data=%0d, required 000 and 0",
                     {prod_tready, out_tvalid, busy}, out_tdata);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        send4(16'sd1, 23'sd0, 23'sd0, 23'sd0, 23'sd0, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd1 || dn !== 16'sd1) begin
            failures++;
            $display("FAIL reset_mid_fresh: got %0d/%0d, required 1/1", d, dn);
        end
    endtask

    task automatic test_clear;
        bit ok, ok2;
        logic signed [15:0] d, dn;
        bias = 16'sd0;
        push(23'sd1000, ok);
        push(23'sd1000, ok2); ok &= ok2;
        push(23'sd1000, ok2); ok &= ok2;
        prod_tdata  = 23'sd1000;
        prod_tvalid = 1'b1;
        clear       = 1'b1;
        #1;
        checks++;
        if (!ok || prod_tready !== 1'b0) begin
            failures++;
            $display("FAIL clear_ready: got %b (ok=%b), required 0", prod_tready, ok);
        end
        @(negedge ap_clk);
        clear       = 1'b0;
        prod_tvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle: busy=%b valid=%b, required 0 0", busy, out_tvalid);
        end
        @(negedge ap_clk);
        send4(16'sd0, 23'sd64, 23'sd64, 23'sd64, 23'sd64, ok);
        take(d, dn, ok2);
        checks++;
        if (!ok || !ok2 || d !== 16'sd4 || dn !== 16'sd4) begin
            failures++;
            $display("FAIL clear_next_vector: got %0d/%0d, required 4/4", d, dn);
        end
    endtask

    initial begin
        clear       = 1'b0;
        bias        = '0;
        prod_tdata  = '0;
        prod_tvalid = 1'b0;
        out_tready  = 1'b0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_bias_hold();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
